// File: rtl/local_sram_arbiter.sv
// local_sram_arbiter
//   Arbitrates two local-memory clients (core data port = client 0,
//   wishbone localMemory bus = client 1) onto one shared port of a bank of
//   single-port SRAM macros. Each request is registered, exactly one macro
//   is strobed, and read data returns two cycles after the request is
//   sampled. busy stays high until the response cycle.
//
//   Optional feature: define LOCAL_SRAM_ARBITER_ROUND_ROBIN_EN to alternate
//   grants on simultaneous requests; otherwise client 0 always wins a tie.
//
// Ports
//   wb_clk_i, wb_rst_n_i        clock, async active-low reset
//   coreMemory*                 client 0 request / response
//   localMemory*                client 1 request / response
//   sram_csb0                   per-macro chip select (active-low)
//   sram_web0/wmask0/addr0/din0 shared macro write enable, mask, address, data
//   sram_dout0                  macro read data, macro i on [32i+31:32i]
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight, sample both clients
// ACCESS  | latched request drives the SRAM port
// RESPOND | granted client completes, other client may be sampled

module local_sram_arbiter #(
  parameter int SRAM_ADDRESS_WIDTH = 9,
  parameter int SRAM_COUNT         = 2
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n_i,
  input  logic                          coreMemoryEnable,
  input  logic                          coreMemoryWriteEnable,
  input  logic [3:0]                    coreMemoryByteSelect,
  input  logic [23:0]                   coreMemoryAddress,
  input  logic [31:0]                   coreMemoryDataWrite,
  output logic [31:0]                   coreMemoryDataRead,
  output logic                          coreMemoryBusy,
  input  logic                          localMemoryEnable,
  input  logic                          localMemoryWriteEnable,
  input  logic [3:0]                    localMemoryByteSelect,
  input  logic [23:0]                   localMemoryAddress,
  input  logic [31:0]                   localMemoryDataWrite,
  output logic [31:0]                   localMemoryDataRead,
  output logic                          localMemoryBusy,
  output logic [SRAM_COUNT-1:0]         sram_csb0,
  output logic                          sram_web0,
  output logic [3:0]                    sram_wmask0,
  output logic [SRAM_ADDRESS_WIDTH-1:0] sram_addr0,
  output logic [31:0]                   sram_din0,
  input  logic [32*SRAM_COUNT-1:0]      sram_dout0
);

  localparam int         BANK_W    = (SRAM_COUNT > 1) ? $clog2(SRAM_COUNT) : 0;
  localparam int         RANGE_LSB = SRAM_ADDRESS_WIDTH + 2 + BANK_W;
  localparam logic [1:0] BANK_MASK = 2'(SRAM_COUNT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESPOND} state_t;

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic [1:0]  lat_bank;
  logic        lat_oor;

  logic        pick;
  logic        pick_valid;
  logic        tie_pick;
  logic        pick_we;
  logic [3:0]  pick_sel;
  logic [23:0] pick_addr;
  logic [31:0] pick_wdata;
  logic [1:0]  pick_bank;
  logic        pick_oor;
  logic [SRAM_COUNT-1:0] pick_csb;
  logic [31:0] resp_data;
  logic        resp_core;
  logic        resp_local;

  function automatic logic [1:0] bank_of(input logic [23:0] a);
    logic [23:0] s;
    s = a >> (SRAM_ADDRESS_WIDTH + 2);
    return s[1:0] & BANK_MASK;
  endfunction

  function automatic logic out_of_range(input logic [23:0] a);
    return (a >> RANGE_LSB) != 24'd0;
  endfunction

`ifdef LOCAL_SRAM_ARBITER_ROUND_ROBIN_EN
  assign tie_pick = ~last_grant;
`else
  // Fixed priority: last_grant is still tracked so the register behaves
  // identically in both builds, it just does not steer the tie.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign tie_pick          = 1'b0;
`endif

  // Who may be latched this cycle. In RESPOND only the non-granted client is
  // eligible, so a held enable from the finishing client never re-strobes.
  always_comb begin
    pick       = 1'b0;
    pick_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (coreMemoryEnable && localMemoryEnable) begin
          pick       = tie_pick;
          pick_valid = 1'b1;
        end else if (coreMemoryEnable) begin
          pick       = 1'b0;
          pick_valid = 1'b1;
        end else if (localMemoryEnable) begin
          pick       = 1'b1;
          pick_valid = 1'b1;
        end
      end
      ST_RESPOND: begin
        if (!grant && localMemoryEnable) begin
          pick       = 1'b1;
          pick_valid = 1'b1;
        end else if (grant && coreMemoryEnable) begin
          pick       = 1'b0;
          pick_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pick_we    = pick ? localMemoryWriteEnable : coreMemoryWriteEnable;
  assign pick_sel   = pick ? localMemoryByteSelect  : coreMemoryByteSelect;
  assign pick_addr  = pick ? localMemoryAddress     : coreMemoryAddress;
  assign pick_wdata = pick ? localMemoryDataWrite   : coreMemoryDataWrite;
  assign pick_bank  = bank_of(pick_addr);
  assign pick_oor   = out_of_range(pick_addr);

  // Byte offset bits carry no meaning for a word-wide macro.
  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = pick_addr[1:0];

  always_comb begin
    pick_csb = '1;
    for (int i = 0; i < SRAM_COUNT; i++) begin
      if (!pick_oor && int'(pick_bank) == i) pick_csb[i] = 1'b0;
    end
  end

  // SRAM port is registered so it only changes on the clock edge that enters
  // or leaves ACCESS; nothing from sram_dout0 reaches these outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state       <= ST_IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      lat_bank    <= 2'd0;
      lat_oor     <= 1'b0;
      sram_csb0   <= '1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= 4'h0;
      sram_addr0  <= '0;
      sram_din0   <= 32'h0;
    end else begin
      case (state)
        ST_IDLE, ST_RESPOND: begin
          if (pick_valid) begin
            state       <= ST_ACCESS;
            grant       <= pick;
            last_grant  <= pick;
            lat_bank    <= pick_bank;
            lat_oor     <= pick_oor;
            sram_csb0   <= pick_csb;
            sram_web0   <= ~pick_we;
            sram_wmask0 <= pick_we ? pick_sel : 4'h0;
            sram_addr0  <= pick_addr[SRAM_ADDRESS_WIDTH+1:2];
            sram_din0   <= pick_wdata;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state       <= ST_RESPOND;
          sram_csb0   <= '1;
          sram_web0   <= 1'b1;
          sram_wmask0 <= 4'h0;
          sram_addr0  <= '0;
          sram_din0   <= 32'h0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Macro output is valid the cycle after its strobe, i.e. in RESPOND.
  always_comb begin
    resp_data = 32'hFFFF_FFFF;
    if (!lat_oor) begin
      for (int i = 0; i < SRAM_COUNT; i++) begin
        if (int'(lat_bank) == i) resp_data = sram_dout0[32*i +: 32];
      end
    end
  end

  assign resp_core  = (state == ST_RESPOND) && !grant;
  assign resp_local = (state == ST_RESPOND) &&  grant;

  assign coreMemoryBusy      = coreMemoryEnable  && !resp_core;
  assign localMemoryBusy     = localMemoryEnable && !resp_local;
  assign coreMemoryDataRead  = resp_core  ? resp_data : 32'hFFFF_FFFF;
  assign localMemoryDataRead = resp_local ? resp_data : 32'hFFFF_FFFF;

endmodule

// File: doc/local_sram_arbiter.md
# local_sram_arbiter

Arbitrates two local-memory clients onto one shared port of a bank of single-port SRAM macros. Client 0 is the core data port. Client 1 is the wishbone SRAM interface's `localMemory*` bus, which this block consumes directly. The block registers each request, strobes exactly one SRAM macro, and returns read data with a fixed latency. It holds `busy` high until the response cycle, so both clients use the same busy/enable handshake.

## Interface
- SRAM_ADDRESS_WIDTH, 9, word-address bits per macro (512 x 32-bit).
- SRAM_COUNT, 2, number of macros; power of two, 1..4.
- wb_clk_i  in  1  single clock for block and macros
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low
- coreMemoryEnable / coreMemoryWriteEnable  in  1  client 0 request / write
- coreMemoryByteSelect  in  4  client 0 byte lanes
- coreMemoryAddress  in  24  client 0 byte address
- coreMemoryDataWrite  in  32  client 0 write data
- coreMemoryDataRead  out  32  client 0 read data
- coreMemoryBusy  out  1  client 0 not-complete
- localMemoryEnable, localMemoryWriteEnable, localMemoryByteSelect, localMemoryAddress, localMemoryDataWrite  in  1/1/4/24/32  client 1 request fields, same meaning as client 0
- localMemoryDataRead  out  32  client 1 read data
- localMemoryBusy  out  1  client 1 not-complete
- sram_csb0  out  SRAM_COUNT  per-macro chip select, active-low
- sram_web0  out  1  write enable, active-low, shared
- sram_wmask0  out  4  byte write mask, shared
- sram_addr0  out  SRAM_ADDRESS_WIDTH  word address, shared
- sram_din0  out  32  write data, shared
- sram_dout0  in  32*SRAM_COUNT  read data, macro i on bits [32i+31:32i]; valid the cycle after its strobe

## Operation
- **Request rules**
  - A client requests by holding enable and all fields stable while its busy is 1.
  - The request completes in the cycle where enable=1 and busy=0. Write data is then committed and read data is valid on DataRead.
  - Enable high in any later cycle is a new request.
- **Address decode**
  - word = addr[SRAM_ADDRESS_WIDTH+1:2]; bank = next log2(SRAM_COUNT) bits; addr[1:0] ignored.
  - Any set bit above the bank field (up to bit 23) is out of range. No macro is strobed, writes are dropped, and reads return 32'hFFFF_FFFF with normal latency.
- **FSM states**: IDLE, ACCESS, RESPOND.
  - IDLE: sample eligible requests. If any is present, latch grant, fields, bank and range flag, then go to ACCESS.
  - ACCESS: drive the SRAM from the latched fields. csb0[bank]=0 unless out of range; web0 = !writeEnable; wmask0 = byteSelect for writes, 0 for reads. Always go to RESPOND.
  - RESPOND: granted client's busy=0 and DataRead = sram_dout0 slice[bank] (or all-ones). The other client is sampled here; if it requests, latch it and go to ACCESS, else go to IDLE. The granted client is never sampled in RESPOND.
- **Arbitration** when both request in IDLE: see Configuration. A `lastGrant` register holds the last served client; its reset value is 1 (client 1).
- **Outputs**
  - busyN = enableN && !(state==RESPOND && grant==N); purely combinational.
  - DataRead for a client not in RESPOND = 32'hFFFF_FFFF.
  - SRAM idle values: csb0 all 1, web0 1, wmask0 0, addr0 0, din0 0.
- **Reset** (any time, including mid-access): state IDLE, grant 0, lastGrant 1, latched fields 0, SRAM outputs at idle values. An in-flight request is abandoned; the client sees busy=1 and retries.

## Timing
- A request first sampled at edge N sees ACCESS in cycle N+1 and RESPOND (busy=0) in cycle N+2. Read latency is therefore 2 cycles from sampling.
- Back-to-back alternating clients: one access per 2 cycles.
- Same client repeatedly: one access per 3 cycles, because IDLE is re-entered.
- Both clients request in the same IDLE cycle: the loser's request completes at N+4.
- There is no combinational path from SRAM inputs to the SRAM outputs. DataRead depends combinationally on sram_dout0.

## Configuration
- `LOCAL_SRAM_ARBITER_ROUND_ROBIN_EN`
  - Defined: on a simultaneous request in IDLE, grant the client that is not `lastGrant`.
  - Undefined: client 0 always wins on a simultaneous request. `lastGrant` is still maintained but unused.

## Test plan
- Client 1 writes 0xDEADBEEF to 0x000404, sel 4'hF, then reads 0x000404. Required: csb0 = 2'b10 and addr0 = 9'h101 in ACCESS; busy low exactly 2 cycles after sampling; read returns 0xDEADBEEF.
- Client 0 writes 0x11223344 to 0x000800 with sel 4'h3. Required: csb0 = 2'b01, wmask0 = 4'h3. A later read of 0x000800 returns 0xXXXX3344, with the upper half unchanged from the prior contents.
- Both clients read in the same IDLE cycle after reset. With the macro defined: client 0 served first (RESPOND at N+2), client 1 RESPOND at N+4 with no IDLE in between. Without the macro: client 0 always wins on repeated ties.
- Client 1 reads 0x001000 (out of range for 2x512 words). Required: no csb0 bit low; data 0xFFFFFFFF; busy low at N+2.
- Assert wb_rst_n_i low during ACCESS. Required: csb0 returns to all-ones immediately (asynchronously). After release, a pending enable is resampled and completes at N+2.
- Client 0 holds enable continuously with new addresses. Required: exactly one access per 3 cycles; the RESPOND-cycle enable never causes a duplicate strobe.
